spi_responder: RTL and testbench

SPI mode-0 responder (target) for the far end of the SPI link driven by the controller's divided spi_clk. It runs entirely in the input_clock domain and oversamples spi_clk, spi_cs_n and spi_mosi through synchronizers. Received words are handed off on a valid/ready interface, and transmit words are accepted on a second valid/ready interface. It serves as the on-chip loopback/test peer for the SPI controller and as the target for peripheral-side designs.

---
 rtl/spi_responder_pkg.sv | 15 +
 rtl/sync_edge_detect.sv | 35 +++
 rtl/spi_responder.sv | 155 +++++++++++++++
 tb/tb_spi_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI mode-0 responder.
package spi_responder_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_WORD_WIDTH  = 32;

    // Shifted out whenever no transmit word is held at a word start.
    localparam logic [MAX_WORD_WIDTH-1:0] DEFAULT_TX_IDLE_WORD = '1;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous pin, plus a delay flop that
// turns the synchronized level into single-cycle rise/fall strobes.
module sync_edge_detect
    import spi_responder_pkg::*;
#(
    parameter int   SYNC_STAGES = MIN_SYNC_STAGES,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic input_clock,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delay_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge input_clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            delay_q <= RESET_LEVEL;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            delay_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~delay_q;
    assign fall  = ~level & delay_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder that oversamples the link in the input_clock domain and
// exchanges words over rx/tx valid/ready interfaces.
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter int                    WORD_WIDTH   = 8,
    parameter int                    SYNC_STAGES  = MIN_SYNC_STAGES,
    parameter logic [WORD_WIDTH-1:0] TX_IDLE_WORD = DEFAULT_TX_IDLE_WORD[WORD_WIDTH-1:0]
) (
    input  logic                  input_clock,
    input  logic                  reset,
    input  logic                  spi_clk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [WORD_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    input  logic                  overrun_clear,
    input  logic [WORD_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun
);

    localparam int              CNT_W    = $clog2(WORD_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

    state_e                  state_q, state_d;
    logic                    unused_clk_level, clk_rise, clk_fall;
    logic                    cs_level, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0]  mosi_q;
    logic                    mosi_sync;
    logic [WORD_WIDTH-2:0]   shift_in_q;
    logic [WORD_WIDTH-1:0]   shift_in_next, shift_out_q, hold_q, load_word;
    logic                    hold_full_q, reload_pending_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic                    load_en, shift_en, sample_en, word_done, tx_accept;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_clk_sync (
        .input_clock(input_clock), .reset(reset), .async_in(spi_clk),
        .level(unused_clk_level), .rise(clk_rise), .fall(clk_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_cs_sync (
        .input_clock(input_clock), .reset(reset), .async_in(spi_cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    // MOSI shares the synchronizer depth of spi_clk so data lines up with clk_rise.
    always_ff @(posedge input_clock or negedge reset) begin
        if (!reset) mosi_q <= '0;
        else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    end
    assign mosi_sync = mosi_q[SYNC_STAGES-1];

    always_ff @(posedge input_clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
        state_d   = state_q;
        load_en   = 1'b0;
        shift_en  = 1'b0;
        sample_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = ACTIVE;
                    load_en = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (!cs_level) begin
                    sample_en = clk_rise;
                    load_en   = clk_fall && reload_pending_q;
                    shift_en  = clk_fall && !reload_pending_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_ready      = !hold_full_q;
    assign tx_accept     = tx_valid && tx_ready;
    assign load_word     = hold_full_q ? hold_q : TX_IDLE_WORD;
    assign shift_in_next = {shift_in_q, mosi_sync};
    assign word_done     = sample_en && (bit_cnt_q == LAST_BIT);

    // Transmit side: holding register, shift-out register and MISO.
    // shift_out_q holds the bits still to be sent after the one on spi_miso.
    always_ff @(posedge input_clock or negedge reset) begin
        if (!reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_out_q <= '0;
            spi_miso    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= load_en && !hold_full_q;
            if (tx_accept) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end else if (load_en) begin
                hold_full_q <= 1'b0;
            end
            if (load_en) begin
                shift_out_q <= {load_word[WORD_WIDTH-2:0], 1'b0};
                spi_miso    <= load_word[WORD_WIDTH-1];
            end else if (shift_en) begin
                shift_out_q <= shift_out_q << 1;
                spi_miso    <= shift_out_q[WORD_WIDTH-1];
            end else if (state_d == IDLE) begin
                spi_miso    <= 1'b0;
            end
        end
    end

    // Receive side: bit counter, shift-in register and rx handshake/overrun.
    always_ff @(posedge input_clock or negedge reset) begin
        if (!reset) begin
            bit_cnt_q        <= '0;
            reload_pending_q <= 1'b0;
            shift_in_q       <= '0;
            rx_data          <= '0;
            rx_valid         <= 1'b0;
            rx_overrun       <= 1'b0;
        end else begin
            if (state_q == IDLE || cs_rise) begin
                bit_cnt_q        <= '0;
                reload_pending_q <= 1'b0;
            end else if (word_done) begin
                bit_cnt_q        <= '0;
                reload_pending_q <= 1'b1;
            end else if (sample_en) begin
                bit_cnt_q        <= bit_cnt_q + 1'b1;
            end else if (load_en) begin
                reload_pending_q <= 1'b0;
            end
            if (sample_en) shift_in_q <= shift_in_next[WORD_WIDTH-2:0];
            if (word_done) rx_data <= shift_in_next;
            // A word landing on the handshake cycle re-arms rx_valid without overrun.
            if (word_done)     rx_valid <= 1'b1;
            else if (rx_ready) rx_valid <= 1'b0;
            if (word_done && rx_valid && !rx_ready) rx_overrun <= 1'b1;
            else if (overrun_clear)                 rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: a mode-0 controller model drives the link and
// scoreboards hold the expected received and MISO words.
module tb_spi_responder;
    import spi_responder_pkg::*;

    localparam int W    = 8;
    localparam int HALF = 6;   // spi_clk half period in input_clock cycles

    logic         input_clock = 1'b0;
    logic         reset       = 1'b0;
    logic         spi_clk     = 1'b0;
    logic         spi_cs_n    = 1'b1;
    logic         spi_mosi    = 1'b0;
    logic         spi_miso;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready    = 1'b1;
    logic         rx_overrun;
    logic         overrun_clear = 1'b0;
    logic [W-1:0] tx_data     = '0;
    logic         tx_valid    = 1'b0;
    logic         tx_ready;
    logic         tx_underrun;

    spi_responder #(.WORD_WIDTH(W), .SYNC_STAGES(2)) dut (
        .input_clock(input_clock), .reset(reset),
        .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .overrun_clear(overrun_clear),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_underrun(tx_underrun)
    );

    always #5 input_clock = ~input_clock;

    int           checks = 0;
    int           errors = 0;
    int           rx_pops = 0;
    int           underruns = 0;
    logic [W-1:0] rx_q[$];
    logic [W-1:0] miso_q[$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change #1 after posedge, so a negedge sample sees what the next posedge will take.
    always @(negedge input_clock) begin
        logic [W-1:0] exp_word;
        if (tx_underrun) underruns++;
        if (rx_valid && rx_ready) begin
            rx_pops++;
            if (rx_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL rx_unexpected: observed=%0h expected=none", rx_data);
            end else begin
                exp_word = rx_q.pop_front();
                check("rx_word", rx_data, exp_word);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge input_clock);
        #1;
    endtask

    // Mode-0 controller: MOSI changes while spi_clk is low, MISO sampled on the rise.
    task automatic spi_bits(input logic [W-1:0] word, input int nbits, output logic [W-1:0] got);
        got = '0;
        for (int i = W - 1; i >= W - nbits; i--) begin
            spi_mosi = word[i];
            step(HALF);
            spi_clk = 1'b1;
            got[i]  = spi_miso;
            step(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [W-1:0] mosi_word, input logic [W-1:0] miso_exp);
        logic [W-1:0] got;
        logic [W-1:0] exp_word;
        rx_q.push_back(mosi_word);
        miso_q.push_back(miso_exp);
        spi_bits(mosi_word, W, got);
        exp_word = miso_q.pop_front();
        check("miso_word", got, exp_word);
    endtask

    task automatic cs_end();
        step(HALF);
        spi_cs_n = 1'b1;
        step(HALF);
    endtask

    task automatic push_tx(input logic [W-1:0] data);
        int budget = 100;
        while (!tx_ready && budget > 0) begin
            step(1);
            budget--;
        end
        check("tx_ready_wait", tx_ready, 1'b1);
        tx_data  = data;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    logic [W-1:0] got;
    int           pops0;
    int           u0;

    initial begin
        // Reset values
        step(3);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_overrun", rx_overrun, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_tx_underrun", tx_underrun, 1'b0);
        reset = 1'b1;
        step(4);

        // Single word with a preloaded transmit word
        push_tx(8'hA5);
        check("tx_ready_held", tx_ready, 1'b0);
        pops0 = rx_pops;
        spi_cs_n = 1'b0;
        xfer(8'h3C, 8'hA5);
        cs_end();
        check("single_rx_count", rx_pops - pops0, 1);
        check("tx_ready_freed", tx_ready, 1'b1);

        // Back-to-back words; second tx word arrives during the first word
        push_tx(8'hA5);
        pops0 = rx_pops;
        spi_cs_n = 1'b0;
        step(HALF);
        push_tx(8'h56);
        xfer(8'h12, 8'hA5);
        xfer(8'h34, 8'h56);
        cs_end();
        check("b2b_rx_count", rx_pops - pops0, 2);

        // Underrun at frame start; a tx word is supplied before the trailing reload
        u0 = underruns;
        spi_cs_n = 1'b0;
        step(HALF);
        check("underrun_at_start", underruns - u0, 1);
        push_tx(8'h77);
        xfer(8'h5A, 8'hFF);
        cs_end();
        check("underrun_total", underruns - u0, 1);

        // Overrun: 0x01 is overwritten by 0x02 before it is read
        rx_ready = 1'b0;
        rx_q.push_back(8'h02);
        spi_cs_n = 1'b0;
        spi_bits(8'h01, W, got);
        spi_bits(8'h02, W, got);
        cs_end();
        check("ovr_valid", rx_valid, 1'b1);
        check("ovr_data", rx_data, 8'h02);
        check("ovr_flag", rx_overrun, 1'b1);
        overrun_clear = 1'b1;
        step(1);
        overrun_clear = 1'b0;
        check("ovr_cleared", rx_overrun, 1'b0);
        pops0 = rx_pops;
        rx_ready = 1'b1;
        step(2);
        check("ovr_drain", rx_pops - pops0, 1);

        // Abort after 4 bits, then a clean frame from bit 0
        pops0 = rx_pops;
        spi_cs_n = 1'b0;
        spi_bits(8'hF0, 4, got);
        cs_end();
        check("abort_state", dut.state_q, IDLE);
        check("abort_miso", spi_miso, 1'b0);
        check("abort_rx_valid", rx_valid, 1'b0);
        check("abort_rx_count", rx_pops - pops0, 0);
        push_tx(8'hC3);
        spi_cs_n = 1'b0;
        xfer(8'h96, 8'hC3);
        cs_end();

        // Asynchronous reset during bit 5 with non-reset state on the outputs
        push_tx(8'h81);
        spi_cs_n = 1'b0;
        step(HALF);
        push_tx(8'h44);
        spi_bits(8'hF0, 5, got);
        #2 reset = 1'b0;
        #1;
        check("arst_miso", spi_miso, 1'b0);
        check("arst_rx_data", rx_data, 8'h00);
        check("arst_rx_valid", rx_valid, 1'b0);
        check("arst_rx_overrun", rx_overrun, 1'b0);
        check("arst_tx_ready", tx_ready, 1'b1);
        check("arst_tx_underrun", tx_underrun, 1'b0);
        spi_cs_n = 1'b1;
        step(2);
        reset = 1'b1;
        step(4);
        push_tx(8'hE7);
        spi_cs_n = 1'b0;
        xfer(8'h42, 8'hE7);
        cs_end();

        check("rx_queue_drained", rx_q.size(), 0);
        check("miso_queue_drained", miso_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
